// File: rtl/analog_pad_arbiter_if.sv
// Signal bundle between the analog requesters and the pad arbiter.
// The requester side is the master; the arbiter is the slave.
interface analog_pad_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] sw_en;
    logic [N_REQ-1:0] gnt;
    logic [OW-1:0]    owner;
    logic             busy;

    modport master (output req, input sw_en, gnt, owner, busy);
    modport slave  (input req, output sw_en, gnt, owner, busy);
endinterface

// File: rtl/analog_pad_arbiter.sv
// Round-robin arbiter for a shared analog pad with break-before-make switch
// sequencing: settle interval before grant, guaranteed open interval after release.
module analog_pad_arbiter #(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int BREAK_CYCLES  = 2,
    parameter int CNT_W         = 8
) (
    input  logic                 pclk,
    input  logic                 preset,
    analog_pad_arbiter_if.slave  pad
);
    localparam int                OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BREAK_LOAD  = CNT_W'(BREAK_CYCLES - 1);
    localparam logic [OW-1:0]     PTR_RESET   = OW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, OWN, BREAK} state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] sw_en_q, sw_en_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [OW-1:0]    winner;
    logic [OW-1:0]    idx;
    logic             found;

    // Search starts just after the last winner, so it has lowest priority next round.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = OW'((int'(ptr_q) + i) % N_REQ);
            if (!found && pad.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // through the case can leave a variable unassigned and infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sw_en_d = sw_en_q;
        gnt_d   = gnt_q;

        case (state_q)
            IDLE: begin
                sw_en_d = '0;
                gnt_d   = '0;
                if (|pad.req) begin
                    owner_d = winner;
                    ptr_d   = winner;
                    sw_en_d = N_REQ'(1) << winner;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!pad.req[owner_q]) begin
                    // Requester gave up before settling: open without granting.
                    sw_en_d = '0;
                    cnt_d   = BREAK_LOAD;
                    state_d = BREAK;
                end else if (cnt_q == '0) begin
                    gnt_d   = N_REQ'(1) << owner_q;
                    state_d = OWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OWN: begin
                if (!pad.req[owner_q]) begin
                    sw_en_d = '0;
                    gnt_d   = '0;
                    cnt_d   = BREAK_LOAD;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_RESET;
            cnt_q   <= '0;
            sw_en_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sw_en_q <= sw_en_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign pad.sw_en = sw_en_q;
    assign pad.gnt   = gnt_q;
    assign pad.owner = owner_q;
    assign pad.busy  = busy_q;
endmodule

// File: tb/tb_analog_pad_arbiter.sv
// Scoreboard bench: directed sequences on a default-parameter arbiter plus a
// random stress run on a fast-timing instance with invariant and starvation checks.
module tb_analog_pad_arbiter;
    localparam int N        = 4;
    localparam int SETTLE_A = 8;
    localparam int BREAK_A  = 2;

    typedef enum logic [1:0] {EV_CLOSE, EV_GRANT, EV_OPEN} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] val;
        int         gap;
    } ev_t;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    ev_t  exp_q[$];

    analog_pad_arbiter_if #(.N_REQ(N)) ifa ();
    analog_pad_arbiter_if #(.N_REQ(N)) ifb ();

    analog_pad_arbiter #(
        .N_REQ(N), .SETTLE_CYCLES(SETTLE_A), .BREAK_CYCLES(BREAK_A), .CNT_W(8)
    ) dut_a (
        .pclk(pclk), .preset(preset), .pad(ifa.slave)
    );

    analog_pad_arbiter #(
        .N_REQ(N), .SETTLE_CYCLES(1), .BREAK_CYCLES(1), .CNT_W(8)
    ) dut_b (
        .pclk(pclk), .preset(preset), .pad(ifb.slave)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [3:0] v, input int gap);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input ev_kind_t k, input logic [3:0] v, output int gap);
        ev_t e;
        gap = -1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got %s val=%b, required no event (cycle %0d)",
                     k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(k), 32'(e.kind));
            check("ev_val", 32'(v), 32'(e.val));
            gap = e.gap;
        end
    endtask

    task automatic check_inv(input string tag, input logic [3:0] sw, input logic [3:0] g,
                             input logic [3:0] prev_sw);
        check({tag, "_onehot_sw"}, 32'($onehot0(sw)), 1);
        check({tag, "_gnt_eq_sw"}, 32'(g == 4'b0 || g == sw), 1);
        check({tag, "_no_switch_over"}, 32'(!(prev_sw != 0 && sw != 0 && sw != prev_sw)), 1);
    endtask

    // Monitor for instance A: turns sw_en/gnt edges into events for the scoreboard.
    initial begin : mon_a
        logic [3:0] prev_sw   = '0;
        logic [3:0] prev_gnt  = '0;
        int         open_cyc  = 0;
        int         close_cyc = 0;
        int         gap;
        forever begin
            @(negedge pclk);
            if (prev_sw == 0 && ifa.sw_en != 0) begin
                pop_ev(EV_CLOSE, ifa.sw_en, gap);
                if (gap >= 0) check("break_gap", 32'(cyc - open_cyc), 32'(gap));
                close_cyc = cyc;
            end
            if (prev_gnt == 0 && ifa.gnt != 0) begin
                pop_ev(EV_GRANT, ifa.gnt, gap);
                check("settle_latency", 32'(cyc - close_cyc), SETTLE_A);
            end
            if (prev_sw != 0 && ifa.sw_en == 0) begin
                pop_ev(EV_OPEN, prev_sw, gap);
                open_cyc = cyc;
            end
            check_inv("a", ifa.sw_en, ifa.gnt, prev_sw);
            prev_sw  = ifa.sw_en;
            prev_gnt = ifa.gnt;
        end
    end

    int others_b[N];
    int grants_b = 0;

    // Monitor for instance B: invariants plus bounded wait for every held request.
    initial begin : mon_b
        logic [3:0] prev_sw  = '0;
        logic [3:0] prev_gnt = '0;
        for (int i = 0; i < N; i++) others_b[i] = 0;
        forever begin
            @(negedge pclk);
            for (int i = 0; i < N; i++) if (!ifb.req[i]) others_b[i] = 0;
            if (prev_gnt == 0 && ifb.gnt != 0) begin
                grants_b++;
                for (int i = 0; i < N; i++) begin
                    if (ifb.gnt[i]) begin
                        others_b[i] = 0;
                    end else if (ifb.req[i]) begin
                        others_b[i]++;
                        check("starvation_bound", 32'(others_b[i] <= N - 1), 1);
                    end
                end
            end
            check_inv("b", ifb.sw_en, ifb.gnt, prev_sw);
            prev_sw  = ifb.sw_en;
            prev_gnt = ifb.gnt;
        end
    end

    task automatic do_reset(input logic [3:0] r);
        preset  = 1'b1;
        ifa.req = r;
        ifb.req = '0;
        @(posedge pclk);
        #1;
        check("rst_sw_en", 32'(ifa.sw_en), 0);
        check("rst_gnt", 32'(ifa.gnt), 0);
        check("rst_owner", 32'(ifa.owner), 0);
        check("rst_busy", 32'(ifa.busy), 0);
        preset = 1'b0;
    endtask

    task automatic wait_gnt_a(input logic [3:0] v, input int budget);
        int n = 0;
        while (ifa.gnt !== v && n < budget) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check("gnt_wait", 32'(ifa.gnt), 32'(v));
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (ifa.busy !== 1'b0 && n < budget) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check("idle_wait_a", 32'(ifa.busy), 0);
    endtask

    int st_b[N];
    int hold_b[N];

    initial begin
        ifa.req = '0;
        ifb.req = '0;
        do_reset(4'b0000);

        // Single requester 2: grant exactly SETTLE_A cycles after the switch closes.
        @(posedge pclk);
        #1;
        expect_ev(EV_CLOSE, 4'b0100, -1);
        expect_ev(EV_GRANT, 4'b0100, -1);
        ifa.req = 4'b0100;
        wait_gnt_a(4'b0100, 20);
        check("t1_busy", 32'(ifa.busy), 1);
        check("t1_owner", 32'(ifa.owner), 2);
        expect_ev(EV_OPEN, 4'b0100, -1);
        ifa.req = 4'b0000;
        wait_idle_a(10);

        // Requests 1 and 3 held from reset: 1 first, then 3 after a 3-cycle open gap.
        expect_ev(EV_CLOSE, 4'b0010, -1);
        expect_ev(EV_GRANT, 4'b0010, -1);
        do_reset(4'b1010);
        wait_gnt_a(4'b0010, 20);
        check("t2_owner", 32'(ifa.owner), 1);
        expect_ev(EV_OPEN, 4'b0010, -1);
        expect_ev(EV_CLOSE, 4'b1000, BREAK_A + 1);
        expect_ev(EV_GRANT, 4'b1000, -1);
        ifa.req = 4'b1000;
        wait_gnt_a(4'b1000, 30);
        check("t2_owner3", 32'(ifa.owner), 3);
        expect_ev(EV_OPEN, 4'b1000, -1);
        ifa.req = 4'b0000;
        wait_idle_a(10);

        // Abort during settle: no grant, BREAK_A cycles open, then back to idle.
        @(posedge pclk);
        #1;
        expect_ev(EV_CLOSE, 4'b0100, -1);
        expect_ev(EV_OPEN, 4'b0100, -1);
        ifa.req = 4'b0100;
        @(posedge pclk);
        #1;
        check("t3_sw_closed", 32'(ifa.sw_en), 32'h4);
        repeat (3) @(posedge pclk);
        #1;
        ifa.req = 4'b0000;
        @(posedge pclk);
        #1;
        check("t3_sw_open", 32'(ifa.sw_en), 0);
        check("t3_busy_break0", 32'(ifa.busy), 1);
        @(posedge pclk);
        #1;
        check("t3_busy_break1", 32'(ifa.busy), 1);
        @(posedge pclk);
        #1;
        check("t3_busy_idle", 32'(ifa.busy), 0);
        check("t3_gnt", 32'(ifa.gnt), 0);

        // Reset while owned: outputs clear before the next clock, priority restarts at 0.
        expect_ev(EV_CLOSE, 4'b0001, -1);
        expect_ev(EV_GRANT, 4'b0001, -1);
        ifa.req = 4'b0001;
        wait_gnt_a(4'b0001, 20);
        @(posedge pclk);
        #3;
        expect_ev(EV_OPEN, 4'b0001, -1);
        preset = 1'b1;
        #1;
        check("t4_async_sw_en", 32'(ifa.sw_en), 0);
        check("t4_async_gnt", 32'(ifa.gnt), 0);
        check("t4_async_busy", 32'(ifa.busy), 0);
        expect_ev(EV_CLOSE, 4'b0001, -1);
        expect_ev(EV_GRANT, 4'b0001, -1);
        ifa.req = 4'b1011;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        wait_gnt_a(4'b0001, 20);
        check("t4_owner", 32'(ifa.owner), 0);
        expect_ev(EV_OPEN, 4'b0001, -1);
        ifa.req = 4'b0000;
        wait_idle_a(10);

        // All four held; each releases 10 cycles after grant and re-requests at once.
        begin
            logic [3:0] order[5];
            order[0] = 4'b0001;
            order[1] = 4'b0010;
            order[2] = 4'b0100;
            order[3] = 4'b1000;
            order[4] = 4'b0001;
            for (int r = 0; r < 5; r++) begin
                expect_ev(EV_CLOSE, order[r], (r == 0) ? -1 : BREAK_A + 1);
                expect_ev(EV_GRANT, order[r], -1);
                expect_ev(EV_OPEN, order[r], -1);
            end
            do_reset(4'b1111);
            for (int r = 0; r < 5; r++) begin
                wait_gnt_a(order[r], 30);
                repeat (9) @(posedge pclk);
                #1;
                if (r < 4) begin
                    ifa.req = ifa.req & ~order[r];
                    @(posedge pclk);
                    #1;
                    ifa.req = ifa.req | order[r];
                end else begin
                    ifa.req = 4'b0000;
                end
            end
            wait_idle_a(10);
        end

        // Random stress on the fast instance; requests are held until granted.
        for (int i = 0; i < N; i++) begin
            st_b[i]   = 0;
            hold_b[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge pclk);
            #1;
            for (int i = 0; i < N; i++) begin
                case (st_b[i])
                    0: if ($urandom_range(0, 7) == 0) begin
                        ifb.req[i] = 1'b1;
                        st_b[i]    = 1;
                    end
                    1: if (ifb.gnt[i]) begin
                        st_b[i]   = 2;
                        hold_b[i] = $urandom_range(0, 6);
                    end
                    default: if (hold_b[i] == 0) begin
                        ifb.req[i] = 1'b0;
                        st_b[i]    = 0;
                    end else begin
                        hold_b[i]--;
                    end
                endcase
            end
        end
        ifb.req = '0;
        begin
            int n = 0;
            while (ifb.busy !== 1'b0 && n < 20) begin
                @(posedge pclk);
                #1;
                n++;
            end
            check("idle_wait_b", 32'(ifb.busy), 0);
        end
        check("stress_grants", 32'(grants_b >= 50), 1);

        repeat (3) @(posedge pclk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
